// File: rtl/pmn_mac_if.sv
// pmn_mac_if: request/result bundle for the pmn_mac multiply-accumulate unit.
//
//   start  request a new operation (sampled on the rising clock edge)
//   mc     multiplicand, W bits, sampled with start
//   mp     multiplier, W bits, sampled with start
//   op     1 = two's-complement signed, 0 = unsigned
//   acc    1 = add product to current p, 0 = overwrite p
//   p      2W-bit result register
//   busy   operation in progress
//   done   p holds a completed result
//
// master: requester side, slave: the multiplier.
interface pmn_mac_if #(
   parameter int W = 32
);
   logic             start;
   logic [W-1:0]     mc;
   logic [W-1:0]     mp;
   logic             op;
   logic             acc;
   logic [2*W-1:0]   p;
   logic             busy;
   logic             done;

   modport master (
      output start, mc, mp, op, acc,
      input  p, busy, done
   );

   modport slave (
      input  start, mc, mp, op, acc,
      output p, busy, done
   );
endinterface

// File: rtl/pmn_mac.sv
// pmn_mac: sequential multiply-accumulate unit with a serial/parallel
// multiplier core that produces one product bit per clock.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   pmn_mac_if.slave (start/mc/mp/op/acc in, p/busy/done out)
//
// Requests are registered on the edge that samples start; the FSM acts on
// that registered request one edge later. RUNNING then spends 2W cycles
// generating product bits, so done rises 2W+1 edges after start is sampled.
// A request registered while RUNNING is simply dropped.
module pmn_mac #(
   parameter int W = 32
) (
   input  logic      clk,
   input  logic      rst,
   pmn_mac_if.slave  bus
);
   localparam int PW = 2 * W;
   localparam int CW = $clog2(PW) + 1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUNNING = 2'd1,
      DONE    = 2'd2
   } state_t;

   state_t          state_reg;

   // Input sampling stage.
   logic            start_reg;
   logic [W-1:0]    mc_in_reg;
   logic [W-1:0]    mp_in_reg;
   logic            op_in_reg;
   logic            acc_in_reg;

   // Working registers of the serial core.
   logic [PW-1:0]   mcx_reg;     // extended multiplicand
   logic [W-1:0]    mp_reg;      // multiplier, shifted right each cycle
   logic            op_reg;
   logic            acc_reg;
   logic [CW-1:0]   cnt_reg;
   logic [PW-1:0]   pp_reg;      // running partial sum, already shifted
   logic [PW-1:0]   prod_reg;    // product bits, entering at the MSB
   logic [PW-1:0]   p_reg;

   logic [PW-1:0]   mc_ext;
   logic [PW:0]     sum_next;
   logic [PW-1:0]   prod_next;
   logic            mp_fill;
   logic            last_bit;

   // Multiplicand widened to 2W bits: sign-extended in signed mode,
   // zero-extended otherwise.
   genvar gi;
   for (gi = 0; gi < PW; gi++) begin : g_mc_ext
      if (gi < W) begin : g_low
         assign mc_ext[gi] = mc_in_reg[gi];
      end else begin : g_high
         assign mc_ext[gi] = op_in_reg & mc_in_reg[W-1];
      end
   end

   always_comb begin
      // Add the multiplicand when the current multiplier bit is set; the
      // LSB of the sum is the next product bit, the rest carries forward.
      sum_next  = {1'b0, pp_reg} + (mp_reg[0] ? {1'b0, mcx_reg} : {(PW+1){1'b0}});
      prod_next = {sum_next[0], prod_reg[PW-1:1]};
      // After W shifts the multiplier register is all fill bits, which is
      // exactly the sign extension (signed) or zero (unsigned).
      mp_fill   = op_reg & mp_reg[W-1];
      last_bit  = (cnt_reg == CW'(PW - 1));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= IDLE;
         start_reg  <= 1'b0;
         mc_in_reg  <= '0;
         mp_in_reg  <= '0;
         op_in_reg  <= 1'b0;
         acc_in_reg <= 1'b0;
         mcx_reg    <= '0;
         mp_reg     <= '0;
         op_reg     <= 1'b0;
         acc_reg    <= 1'b0;
         cnt_reg    <= '0;
         pp_reg     <= '0;
         prod_reg   <= '0;
         p_reg      <= '0;
      end else begin
         start_reg <= bus.start;
         if (bus.start) begin
            mc_in_reg  <= bus.mc;
            mp_in_reg  <= bus.mp;
            op_in_reg  <= bus.op;
            acc_in_reg <= bus.acc;
         end

         case (state_reg)
            IDLE, DONE: begin
               if (start_reg) begin
                  mcx_reg   <= mc_ext;
                  mp_reg    <= mp_in_reg;
                  op_reg    <= op_in_reg;
                  acc_reg   <= acc_in_reg;
                  cnt_reg   <= '0;
                  pp_reg    <= '0;
                  prod_reg  <= '0;
                  state_reg <= RUNNING;
               end
            end
            RUNNING: begin
               pp_reg   <= sum_next[PW:1];
               prod_reg <= prod_next;
               mp_reg   <= {mp_fill, mp_reg[W-1:1]};
               cnt_reg  <= cnt_reg + 1'b1;
               if (last_bit) begin
                  // Carry-out of the accumulation is discarded (mod 2^2W).
                  p_reg     <= acc_reg ? (p_reg + prod_next) : prod_next;
                  state_reg <= DONE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign bus.p    = p_reg;
   assign bus.busy = (state_reg == RUNNING);
   assign bus.done = (state_reg == DONE);
endmodule

// File: tb/tb_pmn_mac.sv
// tb_pmn_mac: self-checking bench for pmn_mac at W=8 and W=32.
// Expected results come from plain-arithmetic products mod 2^(2W).
module tb_pmn_mac;
   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   pmn_mac_if #(.W(8))  bus8 ();
   pmn_mac_if #(.W(32)) bus32 ();

   pmn_mac #(.W(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8.slave));
   pmn_mac #(.W(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32.slave));

   int checks = 0;
   int errors = 0;
   logic [15:0] exp8  = '0;
   logic [63:0] exp32 = '0;

   function automatic logic [15:0] model8(input logic [7:0] a, input logic [7:0] b,
                                          input logic op, input logic acc,
                                          input logic [15:0] prev);
      logic signed [15:0] sa, sb;
      logic [15:0] prod;
      sa = $signed(a);
      sb = $signed(b);
      if (op) prod = 16'(sa * sb);
      else    prod = 16'(a) * 16'(b);
      return acc ? 16'(prev + prod) : prod;
   endfunction

   function automatic logic [63:0] model32(input logic [31:0] a, input logic [31:0] b,
                                           input logic op, input logic acc,
                                           input logic [63:0] prev);
      longint sa, sb;
      logic [63:0] prod;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (op) prod = 64'(sa * sb);
      else    prod = 64'(a) * 64'(b);
      return acc ? 64'(prev + prod) : prod;
   endfunction

   // Drive one start pulse; returns 1 time unit after the sampling edge.
   task automatic launch8(input logic [7:0] a, input logic [7:0] b,
                          input logic op, input logic acc);
      bus8.mc = a; bus8.mp = b; bus8.op = op; bus8.acc = acc; bus8.start = 1'b1;
      @(posedge clk); #1;
      bus8.start = 1'b0;
   endtask

   task automatic launch32(input logic [31:0] a, input logic [31:0] b,
                           input logic op, input logic acc);
      bus32.mc = a; bus32.mp = b; bus32.op = op; bus32.acc = acc; bus32.start = 1'b1;
      @(posedge clk); #1;
      bus32.start = 1'b0;
   endtask

   // Edges until done is seen (-1 on timeout), plus busy cycles before it.
   task automatic wait8(output int lat, output int bcnt);
      lat = -1; bcnt = 0;
      for (int i = 1; i <= 200; i++) begin
         @(posedge clk); #1;
         if (bus8.done === 1'b1) begin lat = i; break; end
         if (bus8.busy === 1'b1) bcnt++;
      end
   endtask

   task automatic wait32(output int lat, output int bcnt);
      lat = -1; bcnt = 0;
      for (int i = 1; i <= 400; i++) begin
         @(posedge clk); #1;
         if (bus32.done === 1'b1) begin lat = i; break; end
         if (bus32.busy === 1'b1) bcnt++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         checks++;
         if (bus8.p !== 16'h0 || bus8.busy !== 1'b0 || bus8.done !== 1'b0 ||
             bus32.p !== 64'h0 || bus32.busy !== 1'b0 || bus32.done !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: p8=%h busy8=%b done8=%b p32=%h busy32=%b done32=%b, required all zero",
                     bus8.p, bus8.busy, bus8.done, bus32.p, bus32.busy, bus32.done);
         end
      end
      exp8 = '0; exp32 = '0;
      // start together with rst must not launch anything
      bus8.mc = 8'h12; bus8.mp = 8'h34; bus8.op = 1'b0; bus8.acc = 1'b0;
      rst = 1'b1; bus8.start = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; bus8.start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (bus8.busy !== 1'b0 || bus8.done !== 1'b0) begin
            errors++;
            $display("FAIL start_with_rst: busy=%b done=%b, required 0 0", bus8.busy, bus8.done);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_signed8();
      int lat, bcnt;
      launch8(8'hFD, 8'h05, 1'b1, 1'b0);
      wait8(lat, bcnt);
      checks++;
      if (lat !== 17 || bcnt !== 16 || bus8.p !== 16'hFFF1) begin
         errors++;
         $display("FAIL signed8_fd_05: lat=%0d busy=%0d p=%h, required 17 16 fff1", lat, bcnt, bus8.p);
      end
      exp8 = model8(8'hFD, 8'h05, 1'b1, 1'b0, exp8);
      launch8(8'h80, 8'h80, 1'b1, 1'b0);
      wait8(lat, bcnt);
      checks++;
      if (lat !== 17 || bus8.p !== 16'h4000) begin
         errors++;
         $display("FAIL signed8_80_80: lat=%0d p=%h, required 17 4000", lat, bus8.p);
      end
      exp8 = model8(8'h80, 8'h80, 1'b1, 1'b0, exp8);
   endtask

   task automatic test_unsigned8();
      int lat, bcnt;
      launch8(8'hFF, 8'hFF, 1'b0, 1'b0);
      wait8(lat, bcnt);
      checks++;
      if (lat !== 17 || bus8.p !== 16'hFE01) begin
         errors++;
         $display("FAIL unsigned8_ff_ff: lat=%0d p=%h, required 17 fe01", lat, bus8.p);
      end
      launch8(8'hFF, 8'hFF, 1'b0, 1'b1);
      wait8(lat, bcnt);
      checks++;
      if (lat !== 17 || bus8.p !== 16'hFC02) begin
         errors++;
         $display("FAIL unsigned8_acc_wrap: lat=%0d p=%h, required 17 fc02", lat, bus8.p);
      end
      exp8 = model8(8'hFF, 8'hFF, 1'b0, 1'b0, exp8);
      exp8 = model8(8'hFF, 8'hFF, 1'b0, 1'b1, exp8);
   endtask

   task automatic test_w32();
      int lat, bcnt;
      launch32(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0);
      wait32(lat, bcnt);
      checks++;
      if (lat !== 65 || bcnt !== 64 || bus32.p !== 64'h4000_0000_0000_0000) begin
         errors++;
         $display("FAIL w32_signed_min: lat=%0d busy=%0d p=%h, required 65 64 4000000000000000", lat, bcnt, bus32.p);
      end
      launch32(32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 1'b0);
      wait32(lat, bcnt);
      checks++;
      if (lat !== 65 || bus32.p !== 64'h0000_0001_FFFF_FFFE) begin
         errors++;
         $display("FAIL w32_unsigned: lat=%0d p=%h, required 65 00000001fffffffe", lat, bus32.p);
      end
      exp32 = model32(32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 1'b0, exp32);
   endtask

   task automatic test_acc_chain();
      int lat, bcnt;
      launch8(8'd10, 8'd10, 1'b0, 1'b0);
      wait8(lat, bcnt);
      checks++;
      if (bus8.p !== 16'h0064) begin
         errors++;
         $display("FAIL chain_10x10: p=%h, required 0064", bus8.p);
      end
      launch8(8'd3, 8'd4, 1'b0, 1'b1);
      wait8(lat, bcnt);
      checks++;
      if (bus8.p !== 16'h0070) begin
         errors++;
         $display("FAIL chain_acc_3x4: p=%h, required 0070", bus8.p);
      end
      launch8(8'hFF, 8'h01, 1'b1, 1'b1);
      wait8(lat, bcnt);
      checks++;
      if (bus8.p !== 16'h006F) begin
         errors++;
         $display("FAIL chain_acc_signed: p=%h, required 006f", bus8.p);
      end
      exp8 = 16'h006F;
   endtask

   task automatic test_random8();
      int lat, bcnt;
      logic [7:0] a, b;
      logic op, acc;
      for (int n = 0; n < 24; n++) begin
         a = 8'($urandom); b = 8'($urandom);
         op = 1'($urandom_range(0, 1)); acc = 1'($urandom_range(0, 1));
         launch8(a, b, op, acc);
         wait8(lat, bcnt);
         exp8 = model8(a, b, op, acc, exp8);
         checks++;
         if (lat !== 17 || bus8.p !== exp8) begin
            errors++;
            $display("FAIL random8 #%0d (%h*%h op=%b acc=%b): lat=%0d p=%h, required 17 %h",
                     n, a, b, op, acc, lat, bus8.p, exp8);
         end
      end
   endtask

   task automatic test_random32();
      int lat, bcnt;
      logic [31:0] a, b;
      logic op, acc;
      for (int n = 0; n < 6; n++) begin
         a = $urandom; b = $urandom;
         op = 1'($urandom_range(0, 1)); acc = 1'($urandom_range(0, 1));
         launch32(a, b, op, acc);
         wait32(lat, bcnt);
         exp32 = model32(a, b, op, acc, exp32);
         checks++;
         if (lat !== 65 || bus32.p !== exp32) begin
            errors++;
            $display("FAIL random32 #%0d (%h*%h op=%b acc=%b): lat=%0d p=%h, required 65 %h",
                     n, a, b, op, acc, lat, bus32.p, exp32);
         end
      end
   endtask

   task automatic test_ignore_during_run();
      int lat, bcnt, bad;
      logic [7:0] a, b;
      logic op;
      a = 8'($urandom); b = 8'($urandom); op = 1'($urandom_range(0, 1));
      launch8(a, b, op, 1'b0);
      repeat (4) @(posedge clk);
      #1;
      launch8(~a, b + 8'd1, ~op, 1'b1);   // sampled at edge k+5, mid-run
      wait8(lat, bcnt);
      exp8 = model8(a, b, op, 1'b0, exp8);
      checks++;
      if (lat !== 12 || bus8.p !== exp8) begin
         errors++;
         $display("FAIL ignore_midrun_start: lat=%0d p=%h, required 12 %h", lat, bus8.p, exp8);
      end
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (bus8.busy !== 1'b0 || bus8.done !== 1'b1 || bus8.p !== exp8) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL dropped_request_queued: %0d bad cycles, required 0", bad);
      end
   endtask

   task automatic test_back_to_back();
      int lat, bcnt, rises, last_rise;
      logic prev_done;
      logic [7:0] a, b;
      logic op;
      a = 8'($urandom); b = 8'($urandom); op = 1'($urandom_range(0, 1));
      bus8.mc = a; bus8.mp = b; bus8.op = op; bus8.acc = 1'b1; bus8.start = 1'b1;
      prev_done = bus8.done;
      rises = 0; last_rise = -1;
      for (int i = 1; i <= 120 && rises < 4; i++) begin
         @(posedge clk); #1;
         if (bus8.done === 1'b1 && prev_done !== 1'b1) begin
            rises++;
            exp8 = model8(a, b, op, 1'b1, exp8);
            checks++;
            if (bus8.p !== exp8 || (last_rise >= 0 && i - last_rise != 17)) begin
               errors++;
               $display("FAIL back_to_back result %0d: p=%h interval=%0d, required %h 17",
                        rises, bus8.p, i - last_rise, exp8);
            end
            last_rise = i;
         end
         prev_done = bus8.done;
      end
      bus8.start = 1'b0;
      checks++;
      if (rises != 4) begin
         errors++;
         $display("FAIL back_to_back_count: %0d results, required 4", rises);
      end
      // start was still high on the last done edge, so one more op runs
      wait8(lat, bcnt);
      exp8 = model8(a, b, op, 1'b1, exp8);
      checks++;
      if (lat !== 17 || bus8.p !== exp8) begin
         errors++;
         $display("FAIL back_to_back_tail: lat=%0d p=%h, required 17 %h", lat, bus8.p, exp8);
      end
   endtask

   task automatic test_reset_mid_run();
      int lat, bcnt, bad;
      logic [7:0] a, b;
      logic op;
      a = 8'($urandom); b = 8'($urandom); op = 1'($urandom_range(0, 1));
      launch8(a, b, op, 1'b0);
      repeat (5) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      exp8 = '0; exp32 = '0;
      checks++;
      if (bus8.p !== 16'h0 || bus8.busy !== 1'b0 || bus8.done !== 1'b0 || bus32.p !== 64'h0) begin
         errors++;
         $display("FAIL reset_midrun: p8=%h busy=%b done=%b p32=%h, required 0 0 0 0",
                  bus8.p, bus8.busy, bus8.done, bus32.p);
      end
      bad = 0;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk); #1;
         if (bus8.done !== 1'b0 || bus8.busy !== 1'b0) bad++;
      end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL reset_no_done: %0d cycles with busy/done, required 0", bad);
      end
      launch8(a, b, op, 1'b1);   // accumulates onto p=0
      wait8(lat, bcnt);
      exp8 = model8(a, b, op, 1'b1, exp8);
      checks++;
      if (lat !== 17 || bus8.p !== exp8) begin
         errors++;
         $display("FAIL after_reset_op: lat=%0d p=%h, required 17 %h", lat, bus8.p, exp8);
      end
   endtask

   initial begin
      bus8.start = 1'b0;  bus8.mc = '0;  bus8.mp = '0;  bus8.op = 1'b0;  bus8.acc = 1'b0;
      bus32.start = 1'b0; bus32.mc = '0; bus32.mp = '0; bus32.op = 1'b0; bus32.acc = 1'b0;
      test_reset();
      test_signed8();
      test_unsigned8();
      test_w32();
      test_acc_chain();
      test_random8();
      test_random32();
      test_ignore_during_run();
      test_back_to_back();
      test_reset_mid_run();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/pmn_mac.md
# pmn_mac

Parametrised sequential multiply-accumulate unit built on a serial/parallel multiplier core, one product bit per clock. It generalises the fixed 32-bit signed multiplier to any operand width W and adds a per-operation signed/unsigned mode, optional accumulation into the previous result and an explicit busy/done handshake. It sits beside the existing arithmetic blocks as the shared multiplier for control-path and DSP-lite datapaths.

## Interface
- W, default 32: operand width in bits, 4 to 64; the result is 2W bits.
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a new operation; sampled on the rising edge of clk.
- mc  in  W  multiplicand; sampled together with start.
- mp  in  W  multiplier; sampled together with start.
- op  in  1  mode, sampled with start: 1 = two's-complement signed, 0 = unsigned.
- acc  in  1  sampled with start: 1 = add the product to the current p, 0 = overwrite p.
- p  out  2W  result register.
- busy  out  1  high while an operation is in progress.
- done  out  1  high while p holds a completed result.

## Operation
- Reset is synchronous and active-high. On any clk edge with rst=1:
  - state returns to IDLE;
  - p=0, busy=0, done=0;
  - the internal shift registers and counter are cleared.
- rst has priority over start in the same cycle.
- States: IDLE, RUNNING, DONE. All are encoded in a 2-bit register; the unused encoding goes to IDLE.
- IDLE or DONE with start=1:
  - latch mc, mp, op and acc into internal registers;
  - clear the count and the partial-product shift register;
  - go to RUNNING.
- IDLE with start=0: stay in IDLE.
- DONE with start=0: stay in DONE; p and done hold.
- RUNNING ignores start, mc, mp, op and acc. New requests are dropped, not queued.
- RUNNING lasts exactly 2W cycles. The counter is $clog2(2W)+1 bits wide and increments every RUNNING cycle.
- Bit generation:
  - each cycle, the core consumes one bit of the latched multiplier, LSB first;
  - once all W multiplier bits are used, it consumes the sign extension: mp[W-1] if op=1, else 0;
  - the core emits one product bit per cycle, LSB first, into an internal 2W-bit shift register.
- Signed mode (op=1) uses a sign-extended multiplicand in the core. The result equals the two's-complement product mc*mp over 2W bits.
- Unsigned mode (op=0): the result equals the unsigned product over 2W bits.
- On the last RUNNING cycle, p loads one of:
  - product, if the latched acc=0;
  - p + product mod 2^(2W), if the latched acc=1. p is the value held before the operation. The carry-out is discarded; there is no saturation in either mode.
- p changes only on reset or at completion. It holds its old value throughout RUNNING.
- busy = (state==RUNNING), done = (state==DONE). Both are decoded from registered state, so there are no combinational paths from inputs to outputs.
- acc=1 after reset accumulates onto p=0.

## Timing
- Let start=1 be sampled at edge k, in IDLE or DONE.
  - busy=1 and done=0 for the cycles following edges k+1 through k+2W.
  - At edge k+2W+1: p is updated, busy=0, done=1.
- Latency from start to done is 2W+1 cycles; for W=32 that is 65 cycles.
- Back-to-back operation: start held high in DONE at edge k+2W+1 gives the next busy at k+2W+2. Throughput is one result per 2W+1 cycles.
- start high in the same cycle done first rises is legal. The new operation begins and done drops on the next edge.
- Reset mid-RUNNING aborts at the next edge: p=0 and no done pulse. A later start behaves as if from power-up.

## Test plan
- Reset, then idle for 10 cycles → p=0, busy=0, done=0. Start asserted together with rst → still IDLE after that edge.
- W=8, op=1, mc=8'hFD (-3), mp=8'h05 → busy for 16 cycles, done at edge 17, p=16'hFFF1. Repeat with mc=mp=8'h80 → p=16'h4000.
- W=8, op=0, mc=mp=8'hFF → p=16'hFE01. Then acc=1 with the same operands → p=16'hFC02 (wraps mod 2^16).
- W=32, op=1, mc=mp=32'h8000_0000 → done 65 cycles after start, p=64'h4000_0000_0000_0000. Then op=0, mc=32'hFFFF_FFFF, mp=2 → p=64'h0000_0001_FFFF_FFFE.
- W=8 accumulate chain:
  - op=0, acc=0, 10*10 → p=16'h0064;
  - acc=1, 3*4 → p=16'h0070;
  - acc=1, op=1, 8'hFF*8'h01 (-1) → p=16'h006F.
- Boundary handshake, W=8:
  - start pulsed during RUNNING with different operands → ignored, first result intact;
  - start held high continuously → results every 17 cycles;
  - rst at cycle 5 of RUNNING → p=0, no done, and a following operation yields the correct product.
